// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and result signal bundle for alu_cmd_sequencer
//
// Purpose: groups the producer command stream, the ALU issue/completion pair,
// the consumer result stream and the status outputs of the sequencer.
// Ports (signals):
//   cmd_valid/cmd_ready, cmd_opA, cmd_opB, cmd_opcode, cmd_tag  - command in
//   alu_opA, alu_opB, alu_opcode, alu_en                         - ALU issue
//   alu_res, alu_done                                            - ALU completion
//   res_valid/res_ready, res_data, res_opcode, res_tag           - result out
//   timeout_err, busy, fifo_count                                - status
// Modports: slave = sequencer side, master = producer/ALU/consumer side.
interface alu_cmd_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_opA;
  logic [15:0]      cmd_opB;
  logic [1:0]       cmd_opcode;
  logic [TAG_W-1:0] cmd_tag;

  logic [15:0]      alu_opA;
  logic [15:0]      alu_opB;
  logic [1:0]       alu_opcode;
  logic             alu_en;
  logic [31:0]      alu_res;
  logic             alu_done;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [1:0]       res_opcode;
  logic [TAG_W-1:0] res_tag;

  logic             timeout_err;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  cmd_valid, cmd_opA, cmd_opB, cmd_opcode, cmd_tag,
    input  alu_res, alu_done, res_ready,
    output cmd_ready, alu_opA, alu_opB, alu_opcode, alu_en,
    output res_valid, res_data, res_opcode, res_tag,
    output timeout_err, busy, fifo_count
  );

  modport master (
    output cmd_valid, cmd_opA, cmd_opB, cmd_opcode, cmd_tag,
    output alu_res, alu_done, res_ready,
    input  cmd_ready, alu_opA, alu_opB, alu_opcode, alu_en,
    input  res_valid, res_data, res_opcode, res_tag,
    input  timeout_err, busy, fifo_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue/wait/hold sequencer for a multi-cycle ALU
//
// Purpose: buffers commands in a DEPTH-entry FIFO, issues them one at a time to
// the ALU with a one-cycle alu_en pulse, waits for alu_done (bounded by
// TIMEOUT cycles), then holds the result with its tag until the consumer
// accepts it.
// Ports:
//   clk  - rising-edge clock
//   nrst - asynchronous reset, active-high despite its name
//   bus  - alu_cmd_sequencer_if.slave: command in, ALU issue/completion,
//          result out, status (timeout_err, busy, fifo_count)
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                nrst,
  alu_cmd_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  typedef struct packed {
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [1:0]       opcode;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      alu_op_a_q, alu_op_a_d;
  logic [15:0]      alu_op_b_q, alu_op_b_d;
  logic [1:0]       alu_opcode_q, alu_opcode_d;
  logic             alu_en_q, alu_en_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [1:0]       res_opcode_q, res_opcode_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             timeout_err_q, timeout_err_d;

  logic full;
  logic push;
  logic pop;
  cmd_t head;

  assign full = (count_q == CNT_W'(DEPTH));
  // cmd_ready is forced low while reset is held so nothing is accepted then.
  assign bus.cmd_ready = ~full & ~nrst;
  assign push = bus.cmd_valid & bus.cmd_ready;
  // Pop only from IDLE; the head is read from registered storage, so a
  // command pushed this cycle is not visible to the FSM until the next one.
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    timer_d       = timer_q;
    tag_d         = tag_q;
    alu_op_a_d    = alu_op_a_q;
    alu_op_b_d    = alu_op_b_q;
    alu_opcode_d  = alu_opcode_q;
    alu_en_d      = 1'b0;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_opcode_d  = res_opcode_q;
    res_tag_d     = res_tag_q;
    timeout_err_d = timeout_err_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{op_a: bus.cmd_opA, op_b: bus.cmd_opB,
                          opcode: bus.cmd_opcode, tag: bus.cmd_tag};
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          alu_op_a_d   = head.op_a;
          alu_op_b_d   = head.op_b;
          alu_opcode_d = head.opcode;
          tag_d        = head.tag;
          alu_en_d     = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion is tested first so a done on the final cycle still wins.
        if (bus.alu_done) begin
          res_data_d   = bus.alu_res;
          res_opcode_d = alu_opcode_q;
          res_tag_d    = tag_q;
          res_valid_d  = 1'b1;
          state_d      = HOLD;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      timer_q       <= '0;
      tag_q         <= '0;
      alu_op_a_q    <= '0;
      alu_op_b_q    <= '0;
      alu_opcode_q  <= '0;
      alu_en_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_opcode_q  <= '0;
      res_tag_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      timer_q       <= timer_d;
      tag_q         <= tag_d;
      alu_op_a_q    <= alu_op_a_d;
      alu_op_b_q    <= alu_op_b_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_en_q      <= alu_en_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_opcode_q  <= res_opcode_d;
      res_tag_q     <= res_tag_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.alu_opA     = alu_op_a_q;
  assign bus.alu_opB     = alu_op_b_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_en      = alu_en_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_opcode  = res_opcode_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = (state_q != IDLE) | (count_q != '0);
  assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] opc);
    case (opc)
      2'b00:   return {16'h0, a} + {16'h0, b};
      2'b01:   return {16'h0, a} - {16'h0, b};
      2'b10:   return {16'h0, a} * {16'h0, b};
      default: return {16'h0, a ^ b};
    endcase
  endfunction

  // ALU model: acts 2 time units after each rising edge. alu_done pulses for
  // one cycle during the alu_delay-th WAIT cycle after the alu_en cycle.
  int alu_delay = 6;
  bit alu_hang  = 1'b0;
  int alu_cnt   = 0;
  int en_cycles = 0;
  initial begin
    bus.alu_done = 1'b0;
    bus.alu_res  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (nrst) begin
        alu_cnt      = 0;
        bus.alu_done = 1'b0;
      end else if (bus.alu_en) begin
        en_cycles++;
        alu_cnt      = alu_delay;
        bus.alu_done = 1'b0;
      end else if (alu_cnt > 0) begin
        alu_cnt--;
        bus.alu_done = (alu_cnt == 0) && !alu_hang;
        bus.alu_res  = alu_calc(bus.alu_opA, bus.alu_opB, bus.alu_opcode);
      end else begin
        bus.alu_done = 1'b0;
      end
    end
  end

  // Called and returns on a falling edge.
  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] opc, input logic [3:0] tag);
    logic acc;
    acc = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opA    = a;
    bus.cmd_opB    = b;
    bus.cmd_opcode = opc;
    bus.cmd_tag    = tag;
    for (int i = 0; i < 300; i++) begin
      acc = bus.cmd_ready;
      @(negedge clk);
      if (acc) break;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) check("push_accept", acc, 1);
  endtask

  task automatic get_result(input string name, input logic [31:0] exp_data,
                            input logic [3:0] exp_tag, input logic [1:0] exp_opc,
                            input bit chk_lat);
    logic got;
    logic prev_done;
    got = 1'b0;
    prev_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.res_valid) begin
        got = 1'b1;
        break;
      end
      prev_done = bus.alu_done;
      @(negedge clk);
    end
    check({name, "_valid"}, got, 1);
    if (got) begin
      if (chk_lat) check({name, "_done_to_valid"}, prev_done, 1);
      check({name, "_data"}, bus.res_data, exp_data);
      check({name, "_tag"}, bus.res_tag, exp_tag);
      check({name, "_opcode"}, bus.res_opcode, exp_opc);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check({name, "_valid_clear"}, bus.res_valid, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  opc;
    logic [3:0]  tag;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] data0;
  bit   stall_ok;
  bit   quiet_ok;
  bit   seen;

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 2'b10, 4'hA, 6, 32'h0000_000F};
    vecs[1] = '{16'h1234, 16'h0FFF, 2'b00, 4'h1, 1, 32'h0000_2233};
    vecs[2] = '{16'h0005, 16'h0007, 2'b01, 4'h2, 3, 32'hFFFF_FFFE};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 2'b10, 4'h3, 2, 32'hFFFE_0001};
    vecs[4] = '{16'hA5A5, 16'h0F0F, 2'b11, 4'hF, 4, 32'h0000_AAAA};

    nrst           = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_opA    = '0;
    bus.cmd_opB    = '0;
    bus.cmd_opcode = '0;
    bus.cmd_tag    = '0;
    bus.res_ready  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_alu_en", bus.alu_en, 0);
    check("rst_alu_opA", bus.alu_opA, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_tag", bus.res_tag, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_fifo_count", bus.fifo_count, 0);
    nrst = 1'b0;
    @(negedge clk);
    check("rel_cmd_ready", bus.cmd_ready, 1);

    // Single commands, one per table row.
    foreach (vecs[i]) begin
      alu_delay = vecs[i].delay;
      en_cycles = 0;
      push(vecs[i].a, vecs[i].b, vecs[i].opc, vecs[i].tag);
      get_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].tag, vecs[i].opc, 1'b1);
      check($sformatf("vec%0d_en_pulse", i), en_cycles, 1);
      check($sformatf("vec%0d_busy_after", i), bus.busy, 0);
    end

    // Backpressure fill plus consumer stall.
    alu_delay = 3;
    en_cycles = 0;
    for (int i = 0; i < 5; i++) push(16'h0010 + 16'(i), 16'h0002, 2'b00, 4'(i));
    check("fill_count", bus.fifo_count, 4);
    check("fill_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_tag   = 4'h9;
    repeat (3) @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("full_ignores_valid", bus.fifo_count, 4);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.res_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check("stall_first_valid", seen, 1);
    data0    = bus.res_data;
    stall_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== data0 || bus.alu_en) stall_ok = 1'b0;
    end
    check("stall_stable", stall_ok, 1);
    check("stall_one_issue", en_cycles, 1);
    get_result("fill0", 32'h12, 4'h0, 2'b00, 1'b0);
    for (int i = 1; i < 5; i++)
      get_result($sformatf("fill%0d", i), 32'h12 + 32'(i), 4'(i), 2'b00, 1'b1);

    // Timeout: ALU never completes.
    alu_hang = 1'b1;
    push(16'h0001, 16'h0001, 2'b00, 4'h5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.alu_en) seen = 1'b1;
      else @(negedge clk);
    end
    check("to_issue_seen", seen, 1);
    quiet_ok = 1'b1;
    repeat (TIMEOUT) begin
      @(negedge clk);
      if (bus.res_valid || bus.timeout_err) quiet_ok = 1'b0;
    end
    check("to_quiet_in_wait", quiet_ok, 1);
    @(negedge clk);
    check("to_err_set", bus.timeout_err, 1);
    check("to_no_result", bus.res_valid, 0);
    check("to_back_idle", bus.busy, 0);
    alu_hang  = 1'b0;
    alu_delay = 2;
    push(16'h0007, 16'h0008, 2'b00, 4'h6);
    get_result("after_to", 32'h0F, 4'h6, 2'b00, 1'b1);
    check("to_err_sticky", bus.timeout_err, 1);

    // Done on the last WAIT cycle beats the timeout.
    do_reset();
    check("reset_clears_err", bus.timeout_err, 0);
    alu_delay = TIMEOUT;
    push(16'h0100, 16'h0003, 2'b01, 4'h7);
    get_result("collide", 32'h0000_00FD, 4'h7, 2'b01, 1'b1);
    check("collide_no_err", bus.timeout_err, 0);

    // Reset mid-WAIT with two commands queued.
    alu_delay = 100;
    for (int i = 0; i < 3; i++) push(16'h0020, 16'h0001, 2'b00, 4'(8 + i));
    repeat (3) @(negedge clk);
    check("rw_queued", bus.fifo_count, 2);
    check("rw_in_wait", bus.busy, 1);
    nrst = 1'b1;
    #1;
    check("rw_alu_en", bus.alu_en, 0);
    check("rw_fifo_count", bus.fifo_count, 0);
    check("rw_res_valid", bus.res_valid, 0);
    check("rw_busy", bus.busy, 0);
    @(negedge clk);
    nrst = 1'b0;
    en_cycles = 0;
    #1;
    check("rw_cmd_ready", bus.cmd_ready, 1);
    repeat (6) @(negedge clk);
    check("rw_discarded", en_cycles, 0);

    // Reset during the issue cycle drops alu_en at once.
    alu_delay = 3;
    push(16'h0002, 16'h0002, 2'b00, 4'h4);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.alu_en) seen = 1'b1;
      else @(negedge clk);
    end
    check("ri_issue_seen", seen, 1);
    nrst = 1'b1;
    #1;
    check("ri_alu_en_low", bus.alu_en, 0);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
